// File: rtl/mem_wb_stage.sv
// mem_wb_stage -- memory / writeback stage of the RISC-V pipeline.
//
// Decodes the instruction in the decode/execute register and does one of two things.
// Non-memory instructions produce their writeback value combinationally.
// Loads and stores go through a registered req/ack data-memory handshake.
// While an access is outstanding, stall_mem freezes the upstream pipeline
// registers. The load result is returned to the register file in the RESP cycle.
//
// Ports
//   clk, rst               : core clock, synchronous active-high reset
//   instruction_ppl        : instruction being retired
//   PC_ppl                 : its PC (JAL/JALR link value is PC_ppl + 4)
//   ALU_ppl                : ALU result / effective address
//   rdata2_forwarded_ppl   : store data (rs2)
//   wdata, reg_wr          : register-file writeback data and enable
//   stall_mem              : hold upstream pipeline registers
//   misalign               : single-cycle flag for a misaligned access
//   dmem_req/we/addr/wdata/be : registered data-memory request
//   dmem_ack, dmem_rdata   : memory completion strobe and load data
//   dmem_err               : single-cycle pulse when an access is aborted on timeout
//
// Build option
//   DMEM_TIMEOUT_EN : when defined, an access still unacknowledged after
//                     TIMEOUT_CYCLES request cycles is abandoned. dmem_err pulses
//                     and the pipeline continues without a writeback.
//                     When undefined, REQ waits forever and dmem_err is tied to 0.

module mem_wb_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_ppl,
    input  logic [31:0] PC_ppl,
    input  logic [31:0] ALU_ppl,
    input  logic [31:0] rdata2_forwarded_ppl,
    output logic [31:0] wdata,
    output logic        reg_wr,
    output logic        stall_mem,
    output logic        misalign,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;

    // funct3[1:0] encodes the access size: 00 byte, 01 half, 1x word.
    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] k);
        case (size)
            2'b00:   store_be = 4'b0001 << k;
            2'b01:   store_be = 4'b0011 << k;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   store_data = {4{d[7:0]}};
            2'b01:   store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [31:0] rd_word,
                                             input logic [1:0] k);
        logic        [31:0] sh;
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        logic signed [31:0] r_s;
        sh  = rd_word >> {k, 3'b000};
        b_s = sh[7:0];
        h_s = sh[15:0];
        case (f3)
            3'b000:  r_s = 32'(b_s);              // LB, sign-extended
            3'b001:  r_s = 32'(h_s);              // LH, sign-extended
            3'b100:  r_s = {24'd0, sh[7:0]};      // LBU
            3'b101:  r_s = {16'd0, sh[15:0]};     // LHU
            default: r_s = sh;                    // LW
        endcase
        load_fmt = r_s;
    endfunction

    state_t      state;
    logic [31:0] ld_q;
    logic [2:0]  ld_f3_q;
    logic [1:0]  ld_k_q;

    logic [4:0] opc;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       is_load, is_store, is_link, is_branch, is_mem;
    logic       misaligned, mem_go;

    assign opc       = instruction_ppl[6:2];
    assign funct3    = instruction_ppl[14:12];
    assign rd        = instruction_ppl[11:7];
    assign is_load   = (opc == OPC_LOAD);
    assign is_store  = (opc == OPC_STORE);
    assign is_link   = (opc == OPC_JAL) || (opc == OPC_JALR);
    assign is_branch = (opc == OPC_BRANCH);
    assign is_mem    = is_load || is_store;

    assign misaligned = ((funct3[1:0] == 2'b01) && ALU_ppl[0]) ||
                        (funct3[1] && (ALU_ppl[1:0] != 2'b00));
    assign mem_go     = is_mem && !misaligned;

    // Writeback, stall and misalign are combinational off the held instruction.
    // A load only writes back in RESP. By then the loaded value is parked in ld_q.
    always_comb begin
        wdata     = ALU_ppl;
        reg_wr    = 1'b1;
        stall_mem = 1'b0;
        misalign  = 1'b0;
        if (is_load) begin
            wdata  = ld_q;
            reg_wr = (state == RESP) && !dmem_err;
        end else if (is_store || is_branch) begin
            reg_wr = 1'b0;
        end else if (is_link) begin
            wdata = PC_ppl + 32'd4;
        end
        if (is_mem && misaligned && (state == IDLE)) begin
            misalign = 1'b1;
            reg_wr   = 1'b0;
        end
        if (rd == 5'd0) begin
            reg_wr = 1'b0;
        end
        stall_mem = ((state == IDLE) && mem_go) || (state == REQ);
        if (rst) begin
            reg_wr    = 1'b0;
            stall_mem = 1'b0;
            misalign  = 1'b0;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;
`else
    assign dmem_err = 1'b0;
`endif

    // Stage boundary: IDLE issues the request; REQ waits for ack (or timeout); RESP retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            dmem_be    <= 4'd0;
`ifdef DMEM_TIMEOUT_EN
            dmem_err   <= 1'b0;
            to_cnt     <= '0;
`endif
        end else begin
`ifdef DMEM_TIMEOUT_EN
            dmem_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (mem_go) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_store;
                        dmem_addr  <= {ALU_ppl[31:2], 2'b00};
                        dmem_wdata <= store_data(funct3[1:0], rdata2_forwarded_ppl);
                        dmem_be    <= is_store ? store_be(funct3[1:0], ALU_ppl[1:0]) : 4'b1111;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        state    <= RESP;
`ifdef DMEM_TIMEOUT_EN
                        to_cnt   <= '0;
`endif
                    end
`ifdef DMEM_TIMEOUT_EN
                    else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        dmem_req <= 1'b0;
                        dmem_err <= 1'b1;
                        to_cnt   <= '0;
                        state    <= RESP;
                    end else begin
                        to_cnt <= to_cnt + CNT_W'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Load formatting context and result. These are data registers, so they have no reset.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && mem_go) begin
            ld_f3_q <= funct3;
            ld_k_q  <= ALU_ppl[1:0];
        end
        if ((state == REQ) && dmem_ack) begin
            ld_q <= load_fmt(ld_f3_q, dmem_rdata, ld_k_q);
        end
    end

    // Instruction fields this stage does not decode.
    logic unused_bits;
`ifdef DMEM_TIMEOUT_EN
    assign unused_bits = ^{instruction_ppl[31:15], instruction_ppl[1:0]};
`else
    assign unused_bits = ^{instruction_ppl[31:15], instruction_ppl[1:0], (TIMEOUT_CYCLES > 0)};
`endif

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory/writeback stage of the RISC-V core pipeline. It consumes the decode/execute pipeline registers (instruction, PC, ALU result, forwarded rs2 data), runs loads and stores over a req/ack data-memory handshake, and returns the writeback value and enable to the register file in decode. While a memory access is in flight it holds the front of the pipeline with `stall_mem`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: number of request cycles without ack before an access is aborted. Used only when the timeout feature is compiled in.

Ports:
- `clk` in 1: core clock. One clock domain; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `instruction_ppl` in 32: instruction from the decode/execute register.
- `PC_ppl` in 32: PC of that instruction.
- `ALU_ppl` in 32: ALU result, which is the effective address for loads and stores.
- `rdata2_forwarded_ppl` in 32: store data (rs2).
- `wdata` out 32: writeback data to the register file.
- `reg_wr` out 1: register-file write enable.
- `stall_mem` out 1: holds all upstream pipeline registers.
- `misalign` out 1: one-cycle pulse when an access is misaligned.
- `dmem_req` out 1: request valid, registered.
- `dmem_we` out 1: 1 = store, 0 = load, registered.
- `dmem_addr` out 32: word-aligned address `{ALU_ppl[31:2], 2'b00}`, registered.
- `dmem_wdata` out 32: lane-replicated store data, registered.
- `dmem_be` out 4: byte enables, registered.
- `dmem_ack` in 1: one-cycle completion strobe from memory.
- `dmem_rdata` in 32: load data, valid when `dmem_ack` is high.
- `dmem_err` out 1: one-cycle pulse on timeout abort.

## Operation
Instruction class is decoded from `opcode[6:2]`.

**Writeback sources**
- Load (00000): the access result.
- Store (01000): no writeback.
- JAL (11011) and JALR (11001): `PC_ppl + 4`.
- Branch (11000): no writeback.
- All other classes: `ALU_ppl`.
- `reg_wr` is forced to 0 when rd (`instruction_ppl[11:7]`) is 0.

**Non-memory instructions**
- Writeback is combinational in the same cycle.
- `stall_mem` stays 0 and the FSM does not leave IDLE.

**Alignment**
- Halfword access with `addr[0]` = 1 is misaligned.
- Word access with `addr[1:0]` ≠ 0 is misaligned.
- On a misaligned access: `misalign` = 1 for that cycle, no request, `reg_wr` = 0, no stall.

**Store lanes**, where k = `addr[1:0]`
- SB: `be = 4'b0001 << k`, data = byte replicated ×4.
- SH: `be = 4'b0011 << k`, data = halfword replicated ×2.
- SW: `be = 4'b1111`.
- Loads drive `be = 4'b1111`.

**Load extraction**
- Select the byte or halfword at offset k from `dmem_rdata`.
- LB and LH sign-extend; LBU and LHU zero-extend; LW passes all 32 bits.

**FSM states**
- IDLE: an aligned memory op in `instruction_ppl` → `stall_mem` = 1, load the `dmem_*` registers, go to REQ.
- REQ: `dmem_req` = 1 and `stall_mem` = 1. Address, data and enables are held stable until ack. On `dmem_ack`: capture the formatted load data into `ld_q`, go to RESP.
- RESP: `stall_mem` = 0 and `dmem_req` = 0. For a load, `reg_wr` = 1 and `wdata` = `ld_q`. Go to IDLE. The pipeline advances on this edge.

## Timing
**Reset values**
- Every registered output is 0: `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_be`.
- `misalign` and `dmem_err` are 0.
- FSM is in IDLE and the timeout counter is 0.
- While `rst` is high, `reg_wr` = 0 and `stall_mem` = 0.

**Latency**
- Minimum memory op is 3 cycles (IDLE → REQ → RESP), with ack in the first REQ cycle.
- Each extra wait cycle adds one.

**Handshake rules**
- An ack sampled in IDLE or RESP is ignored.
- `dmem_req` drops in the cycle after the ack edge. There is exactly one ack per request and no back-to-back pipelining.
- A memory op that immediately follows one in RESP is first seen in IDLE on the next cycle and re-stalls there. There is no bubble beyond that one cycle.

**Reset mid-operation**
- Abandon the access and drop `dmem_req` on the next edge.
- A late ack after reset is ignored.

## Configuration
- `DMEM_TIMEOUT_EN` defined:
  - A saturating counter increments in REQ.
  - When it reaches `TIMEOUT_CYCLES`: `dmem_err` pulses for one cycle, `dmem_req` drops, the FSM goes to RESP with `reg_wr` = 0, and the pipeline continues.
  - The counter clears on leaving REQ.
- `DMEM_TIMEOUT_EN` undefined:
  - REQ waits indefinitely.
  - `dmem_err` is tied to 0 and the counter is absent.

## Test plan
- ADDI x5 with `ALU_ppl` = 0x0000_0123 → same cycle `reg_wr` = 1, `wdata` = 0x123, `stall_mem` = 0.
- SB at address 0x1003, rs2 = 0x0000_00A5, ack after 2 wait cycles → `be` = 1000, `dmem_wdata` = 0xA5A5_A5A5, `dmem_addr` = 0x1000, stall for 4 cycles, `reg_wr` never asserted.
- LH at address 0x2002, `dmem_rdata` = 0x8001_7FFF, ack in the first REQ cycle → in RESP `wdata` = 0xFFFF_8001 and `reg_wr` = 1. Repeat as LHU → 0x0000_8001.
- LW at address 0x3001 → `misalign` pulse, `dmem_req` stays 0, no stall, `reg_wr` = 0.
- `rst` asserted in the second REQ cycle, then ack arrives → `dmem_req` is 0 on the next edge, FSM in IDLE, no writeback.
- `DMEM_TIMEOUT_EN` with `TIMEOUT_CYCLES` = 4, ack never arrives → `dmem_err` pulses after 4 REQ cycles, stall releases the following cycle, and the next ADDI writes back normally.
